router_ingress: RTL and testbench
=================================

# router_ingress

Ingress stage of the 1x3 router, sitting directly upstream of the three `router_fifo` instances. It accepts a byte-serial packet from the source, decodes the 2-bit destination from the header, and writes header, payload and parity into the selected FIFO. Header writes carry the `lfd_state` marker. The block applies back-pressure on `busy` and flags parity errors at packet end.

## Interface
- `DATA_W`, default 8: byte width on all data paths.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: high while header and payload bytes are presented; low on the parity byte.
- `data_in` in DATA_W: packet byte. Header layout: [1:0] destination, [7:2] payload length.
- `fifo_full` in 3: full flags of FIFO 0..2.
- `fifo_empty` in 3: empty flags of FIFO 0..2.
- `busy` out 1: source must hold `data_in`/`pkt_valid` stable while high.
- `write_enb` out 3: one-hot FIFO write strobe.
- `lfd_state` out 1: high on the header write cycle only.
- `dout` out DATA_W: byte to the FIFO `data_in`.
- `err` out 1: parity/length error for the last packet, registered.

## Operation
- Reset values: state DECODE; `busy`, `write_enb`, `lfd_state`, `err` all 0; `dout` 0; header, parity and count registers 0.
- **DECODE**: `busy`=0.
  - On `pkt_valid`=1 with dest≠3: latch the header, `addr`, and `len`=data_in[7:2]; set parity register = header; clear the count; clear `err`.
  - Next state is LOAD_FIRST if `fifo_empty[addr]`, else WAIT_EMPTY.
  - Dest=3: byte dropped, stay in DECODE.
- **WAIT_EMPTY**: `busy`=1. Go to LOAD_FIRST when `fifo_empty[addr]`.
- **LOAD_FIRST**: `busy`=1; `dout`=header register; `write_enb[addr]`=1; `lfd_state`=1. Next: LOAD_DATA.
- **LOAD_DATA**: `busy`=`fifo_full[addr]`.
  - `pkt_valid`=1 and not full: `dout`=`data_in`, `write_enb[addr]`=1, parity ^= byte, count+1.
  - `pkt_valid`=0: go to LOAD_PARITY without writing.
- **LOAD_PARITY**: `busy`=`fifo_full[addr]`. When not full: write `data_in` (the parity byte) and go to CHECK.
- **CHECK**: `busy`=1; `err` <= (parity register ≠ received parity) | (count ≠ len). Next: DECODE.
- Writes never go to a full FIFO: `write_enb[addr]` is gated by `~fifo_full[addr]` in every write state.
- Payload count is 6 bits. A packet with more than 63 payload bytes wraps the count, and the length check then fails.

## Timing
- `write_enb`, `lfd_state`, `dout` and `busy` are combinational from state and inputs; the FIFO captures on the same rising edge.
- Header-to-FIFO latency: header accepted at edge N, header written at edge N+1 when the FIFO is empty.
- First payload byte: the source holds it through LOAD_FIRST (busy=1); it is written at edge N+2.
- One payload byte per cycle while not full.
- `err` updates at the CHECK exit edge and holds until the next header accept.
- Packet turnaround: the next header can be accepted in the cycle after CHECK.
- `fifo_full` rising mid-payload: the same cycle shows `busy`=1 and no write; resumes the cycle full drops.
- `rstn` low mid-packet: immediate return to reset values; the partial packet is abandoned in the FIFO, and the FIFO reset handles it.
- `pkt_valid` toggling in DECODE while dest=3: no state change, no write.

## Configuration
- `ROUTER_PARITY_CHECK_EN` defined: `err` includes the parity mismatch term.
- Not defined: parity accumulator removed; `err` reflects the length mismatch only.
- The parity byte is still written, and CHECK is still one cycle, so timing is identical in both builds.

## Structure
- `router_pkg`:
  - state enum (DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, CHECK);
  - `ADDR_INVALID`=2'b11;
  - `NUM_PORTS`=3;
  - `LEN_W`=6.
- Sub-module `router_parity_acc`: XOR accumulator with load/update/clear. It is the only block removed under the macro.

## Test plan
- Header 8'h0D to FIFO1 (empty), payload AA,BB,CC, parity D0.
  - Writes 0D(lfd=1),AA,BB,CC,D0 on `write_enb`=3'b010.
  - `err`=0.
- Same packet with parity 8'h00 -> `err`=1 after CHECK (macro defined); `err`=0 without the macro.
- Header 8'h0E to FIFO2 with `fifo_empty[2]`=0 for 5 cycles.
  - `busy`=1 throughout; no writes.
  - Header written the cycle after empty rises.
- `fifo_full[1]` asserted for 3 cycles before byte BB.
  - `busy`=1 and `write_enb`=0 for 3 cycles.
  - BB written once; FIFO contents unchanged.
- Header 8'h03 (dest 3) -> stays DECODE, no writes; following valid header 8'h04 routed to FIFO0.
- `rstn` low during the payload of the 0D packet -> all outputs 0 within the reset, state DECODE; next packet processed normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router ingress path.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE,
    WAIT_EMPTY,
    LOAD_FIRST,
    LOAD_DATA,
    LOAD_PARITY,
    CHECK
  } state_e;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int         NUM_PORTS    = 3;
  localparam int         LEN_W        = 6;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
    case (addr)
      2'd0:    port_onehot = 3'b001;
      2'd1:    port_onehot = 3'b010;
      2'd2:    port_onehot = 3'b100;
      default: port_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity accumulator (load / update / clear).
// Exists only when ROUTER_PARITY_CHECK_EN is defined.
`ifdef ROUTER_PARITY_CHECK_EN
module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load,
  input  logic              i_update,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_parity
);

  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_data;
    end else if (i_update) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_parity = r_acc;

endmodule
`endif

// File: rtl/router_ingress.sv
// Router ingress: decodes the header, writes header/payload/parity into the selected FIFO.
// Build option ROUTER_PARITY_CHECK_EN adds the parity-mismatch term to err.
module router_ingress
  import router_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic [DATA_W-1:0]    dout,
  output logic                 err
);

  state_e            r_state;
  state_e            w_next;
  logic [DATA_W-1:0] r_header;
  logic [1:0]        r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_count;
  logic              r_err;

  logic [1:0]        w_dest;
  logic [3:0]        w_full_pad;
  logic [3:0]        w_empty_pad;
  logic              w_full_sel;
  logic              w_empty_sel;
  logic              w_empty_dest;
  logic              w_accept;
  logic              w_wr;
  logic              w_pay_wr;
  logic              w_err_next;

  // Padding the flag vectors to 4 entries keeps the 2-bit index in range;
  // address 3 is never latched, so the pad values are never used.
  assign w_dest       = data_in[1:0];
  assign w_full_pad   = {1'b1, fifo_full};
  assign w_empty_pad  = {1'b0, fifo_empty};
  assign w_full_sel   = w_full_pad[r_addr];
  assign w_empty_sel  = w_empty_pad[r_addr];
  assign w_empty_dest = w_empty_pad[w_dest];
  assign w_accept     = (r_state == DECODE) && pkt_valid && (w_dest != ADDR_INVALID);

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    w_wr      = 1'b0;
    w_pay_wr  = 1'b0;
    lfd_state = 1'b0;
    dout      = '0;
    case (r_state)
      DECODE: begin
        if (w_accept) w_next = w_empty_dest ? LOAD_FIRST : WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (w_empty_sel) w_next = LOAD_FIRST;
      end
      LOAD_FIRST: begin
        // Header is held here rather than dropped if the FIFO reports full.
        busy      = 1'b1;
        dout      = r_header;
        lfd_state = ~w_full_sel;
        if (!w_full_sel) begin
          w_wr   = 1'b1;
          w_next = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        busy = w_full_sel;
        dout = data_in;
        if (!pkt_valid) begin
          w_next = LOAD_PARITY;
        end else if (!w_full_sel) begin
          w_wr     = 1'b1;
          w_pay_wr = 1'b1;
        end
      end
      LOAD_PARITY: begin
        busy = w_full_sel;
        dout = data_in;
        if (!w_full_sel) begin
          w_wr   = 1'b1;
          w_next = CHECK;
        end
      end
      CHECK: begin
        busy   = 1'b1;
        w_next = DECODE;
      end
      default: w_next = DECODE;
    endcase
  end

  assign write_enb = w_wr ? port_onehot(r_addr) : '0;

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] w_parity;
  logic [DATA_W-1:0] r_rx_parity;
  logic              w_par_wr;

  assign w_par_wr = (r_state == LOAD_PARITY) && !w_full_sel;

  router_parity_acc #(
    .DATA_W (DATA_W)
  ) u_parity_acc (
    .clk      (clk),
    .rstn     (rstn),
    .i_load   (w_accept),
    .i_update (w_pay_wr),
    .i_clear  (r_state == CHECK),
    .i_data   (data_in),
    .o_parity (w_parity)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_parity <= '0;
    end else if (w_par_wr) begin
      r_rx_parity <= data_in;
    end
  end

  assign w_err_next = (w_parity != r_rx_parity) | (r_count != r_len);
`else
  assign w_err_next = (r_count != r_len);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= DECODE;
      r_header <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_header <= data_in;
        r_addr   <= w_dest;
        r_len    <= data_in[LEN_W+1:2];
        r_count  <= '0;
        r_err    <= 1'b0;
      end
      // Count is LEN_W bits and wraps on oversize packets, which the length check then sees.
      if (w_pay_wr) r_count <= r_count + 1'b1;
      if (r_state == CHECK) r_err <= w_err_next;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_router_ingress.sv
// Self-checking bench for router_ingress: directed scenarios plus randomized packets
// against a packet-level reference model.
module tb_router_ingress;

  localparam int DATA_W = 8;
`ifdef ROUTER_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic       busy;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [7:0] dout;
  logic       err;

  always #5 clk = ~clk;

  router_ingress #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .busy       (busy),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .dout       (dout),
    .err        (err)
  );

  typedef struct {
    logic [2:0] we;
    logic       lfd;
    logic [7:0] d;
    int         cyc;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  wr_t  wlog[$];
  wr_t  exp_q[$];
  logic exp_err = 1'b0;
  int   cyc = 0;
  int   hdr_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rnd_env = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe is logged and must be one-hot and never hit a full FIFO
  always @(negedge clk) begin
    if (rstn === 1'b1 && write_enb !== 3'b000) begin
      wlog.push_back('{write_enb, lfd_state, dout, cyc});
      n_checks++;
      if ($countones(write_enb) != 1 || (write_enb & fifo_full) != 3'b000) begin
        n_fail++;
        $display("FAIL wr_gate: write_enb=%b fifo_full=%b, required one-hot strobe to a non-full FIFO",
                 write_enb, fifo_full);
      end
    end
  end

  // Random FIFO flag environment, offset from the driver's update point
  always @(posedge clk) begin
    #3;
    if (rnd_env) begin
      for (int p = 0; p < 3; p++) begin
        fifo_full[p]  = ($urandom_range(0, 4) == 0);
        fifo_empty[p] = ($urandom_range(0, 4) != 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] par_of(input logic [7:0] hdr, input bq_t pl);
    logic [7:0] x;
    x = hdr;
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  // Reference model: expected FIFO writes of one packet and the resulting err
  function automatic void model_pkt(input logic [7:0] hdr, input bq_t pl, input logic [7:0] par);
    logic [2:0] oh;
    int         n;
    exp_q.delete();
    if (hdr[1:0] == 2'd3) return;
    oh = 3'b001 << hdr[1:0];
    exp_q.push_back('{oh, 1'b1, hdr, 0});
    foreach (pl[i]) exp_q.push_back('{oh, 1'b0, pl[i], 0});
    exp_q.push_back('{oh, 1'b0, par, 0});
    n = pl.size() % 64;
    exp_err = (n != int'(hdr[7:2])) || (PAR_EN && (par_of(hdr, pl) != par));
  endfunction

  // Source driver: header is taken when busy is low; later bytes when they are written
  task automatic send_byte(input logic [7:0] b, input logic v, input bit is_hdr);
    bit done;
    done = 1'b0;
    data_in = b;
    pkt_valid = v;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (is_hdr ? (busy === 1'b0) : (write_enb !== 3'b000 && lfd_state === 1'b0)) begin
        done = 1'b1;
        if (is_hdr) hdr_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake: byte %h not taken in 80 cycles, required acceptance", b);
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input bq_t pl, input logic [7:0] par);
    send_byte(hdr, 1'b1, 1'b1);
    if (hdr[1:0] != 2'd3) begin
      foreach (pl[i]) send_byte(pl[i], 1'b1, 1'b0);
      send_byte(par, 1'b0, 1'b0);
    end
    pkt_valid = 1'b0;
    data_in = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pkt_valid = 1'b1; data_in = 8'h0D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, write_enb, lfd_state, dout, err} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b we=%b lfd=%b dout=%h err=%b, required all 0",
               busy, write_enb, lfd_state, dout, err);
    end
    @(posedge clk); #1;
    rstn = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    @(negedge clk);
    n_checks++;
    if ({busy, write_enb, lfd_state, dout, err} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b we=%b lfd=%b dout=%h err=%b, required all 0",
               busy, write_enb, lfd_state, dout, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bq_t pl;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    wlog.delete();
    model_pkt(8'h0D, pl, 8'hD0);
    send_pkt(8'h0D, pl, 8'hD0);
    n_checks++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count: %0d writes, required %0d", wlog.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      int off;
      n_checks++;
      if (wlog[i].we !== exp_q[i].we || wlog[i].lfd !== exp_q[i].lfd || wlog[i].d !== exp_q[i].d) begin
        n_fail++;
        $display("FAIL basic_wr[%0d]: we=%b lfd=%b d=%h, required we=%b lfd=%b d=%h", i,
                 wlog[i].we, wlog[i].lfd, wlog[i].d, exp_q[i].we, exp_q[i].lfd, exp_q[i].d);
      end
      // header +1, payload one per cycle, one idle cycle before parity
      off = (i == exp_q.size() - 1) ? i + 2 : i + 1;
      n_checks++;
      if (wlog[i].cyc != hdr_cyc + off) begin
        n_fail++;
        $display("FAIL basic_timing[%0d]: cycle %0d, required %0d", i, wlog[i].cyc, hdr_cyc + off);
      end
    end
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL basic_err: err=%b, required %b", err, exp_err);
    end
  endtask

  task automatic test_bad_parity();
    bq_t  pl;
    bq_t  pl2;
    logic held;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    wlog.delete();
    model_pkt(8'h0D, pl, 8'h00);
    send_pkt(8'h0D, pl, 8'h00);
    n_checks++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL badpar_count: %0d writes, required %0d", wlog.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[i].we !== exp_q[i].we || wlog[i].lfd !== exp_q[i].lfd || wlog[i].d !== exp_q[i].d) begin
        n_fail++;
        $display("FAIL badpar_wr[%0d]: we=%b d=%h, required we=%b d=%h", i,
                 wlog[i].we, wlog[i].d, exp_q[i].we, exp_q[i].d);
      end
    end
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL badpar_err: err=%b, required %b", err, exp_err);
    end
    held = exp_err;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (err !== held) begin
      n_fail++;
      $display("FAIL badpar_hold: err=%b, required %b", err, held);
    end
    @(posedge clk); #1;
    pl2 = '{8'h5A};
    wlog.delete();
    model_pkt(8'h04, pl2, par_of(8'h04, pl2));
    send_byte(8'h04, 1'b1, 1'b1);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL badpar_clear: err=%b after header accept, required 0", err);
    end
    send_byte(8'h5A, 1'b1, 1'b0);
    send_byte(par_of(8'h04, pl2), 1'b0, 1'b0);
    pkt_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (err !== exp_err || wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL badpar_next: err=%b writes=%0d, required err=%b writes=%0d",
               err, wlog.size(), exp_err, exp_q.size());
    end
  endtask

  task automatic test_wait_empty();
    bq_t        pl;
    logic [7:0] par;
    int         rise;
    pl = '{8'h11, 8'h22, 8'h33};
    par = par_of(8'h0E, pl);
    wlog.delete();
    model_pkt(8'h0E, pl, par);
    fifo_empty = 3'b011;
    send_byte(8'h0E, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || write_enb !== 3'b000) begin
        n_fail++;
        $display("FAIL wait_busy[%0d]: busy=%b we=%b, required busy=1 we=000", i, busy, write_enb);
      end
      @(posedge clk); #1;
    end
    fifo_empty = 3'b111;
    rise = cyc;
    foreach (pl[i]) send_byte(pl[i], 1'b1, 1'b0);
    send_byte(par, 1'b0, 1'b0);
    pkt_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wait_count: %0d writes, required %0d", wlog.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[i].we !== exp_q[i].we || wlog[i].lfd !== exp_q[i].lfd || wlog[i].d !== exp_q[i].d) begin
        n_fail++;
        $display("FAIL wait_wr[%0d]: we=%b d=%h, required we=%b d=%h", i,
                 wlog[i].we, wlog[i].d, exp_q[i].we, exp_q[i].d);
      end
    end
    if (wlog.size() > 0) begin
      n_checks++;
      if (wlog[0].cyc != rise + 1) begin
        n_fail++;
        $display("FAIL wait_hdr_time: header at cycle %0d, required %0d", wlog[0].cyc, rise + 1);
      end
    end
  endtask

  task automatic test_full_stall();
    bq_t pl;
    int  drop;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    wlog.delete();
    model_pkt(8'h0D, pl, 8'hD0);
    send_byte(8'h0D, 1'b1, 1'b1);
    send_byte(8'hAA, 1'b1, 1'b0);
    data_in = 8'hBB; pkt_valid = 1'b1; fifo_full = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || write_enb !== 3'b000) begin
        n_fail++;
        $display("FAIL full_stall[%0d]: busy=%b we=%b, required busy=1 we=000", i, busy, write_enb);
      end
      @(posedge clk); #1;
    end
    fifo_full = 3'b000;
    drop = cyc;
    send_byte(8'hBB, 1'b1, 1'b0);
    send_byte(8'hCC, 1'b1, 1'b0);
    send_byte(8'hD0, 1'b0, 1'b0);
    pkt_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_count: %0d writes, required %0d", wlog.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[i].we !== exp_q[i].we || wlog[i].lfd !== exp_q[i].lfd || wlog[i].d !== exp_q[i].d) begin
        n_fail++;
        $display("FAIL full_wr[%0d]: we=%b d=%h, required we=%b d=%h", i,
                 wlog[i].we, wlog[i].d, exp_q[i].we, exp_q[i].d);
      end
    end
    if (wlog.size() > 2) begin
      n_checks++;
      if (wlog[2].cyc != drop) begin
        n_fail++;
        $display("FAIL full_resume: BB at cycle %0d, required %0d", wlog[2].cyc, drop);
      end
    end
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL full_err: err=%b, required %b", err, exp_err);
    end
  endtask

  task automatic test_drop_invalid();
    bq_t pl;
    wlog.delete();
    data_in = 8'h03; pkt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || write_enb !== 3'b000 || lfd_state !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_idle[%0d]: busy=%b we=%b lfd=%b, required all 0", i, busy, write_enb, lfd_state);
      end
      @(posedge clk); #1;
      pkt_valid = ~pkt_valid;
    end
    pkt_valid = 1'b0;
    pl = '{8'h5A};
    model_pkt(8'h04, pl, par_of(8'h04, pl));
    send_pkt(8'h04, pl, par_of(8'h04, pl));
    n_checks++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL drop_count: %0d writes, required %0d", wlog.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[i].we !== exp_q[i].we || wlog[i].lfd !== exp_q[i].lfd || wlog[i].d !== exp_q[i].d) begin
        n_fail++;
        $display("FAIL drop_wr[%0d]: we=%b d=%h, required we=%b d=%h", i,
                 wlog[i].we, wlog[i].d, exp_q[i].we, exp_q[i].d);
      end
    end
    if (wlog.size() > 0) begin
      n_checks++;
      if (wlog[0].cyc != hdr_cyc + 1) begin
        n_fail++;
        $display("FAIL drop_hdr_time: header at cycle %0d, required %0d", wlog[0].cyc, hdr_cyc + 1);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bq_t pl;
    pl = '{8'hAA, 8'hBB};
    model_pkt(8'h0D, pl, par_of(8'h0D, pl));
    send_pkt(8'h0D, pl, par_of(8'h0D, pl));
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL len_err: err=%b, required %b", err, exp_err);
    end
    send_byte(8'h0D, 1'b1, 1'b1);
    send_byte(8'hAA, 1'b1, 1'b0);
    data_in = 8'hBB; pkt_valid = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, write_enb, lfd_state, dout, err} !== 13'b0) begin
      n_fail++;
      $display("FAIL midreset: busy=%b we=%b lfd=%b dout=%h err=%b, required all 0",
               busy, write_enb, lfd_state, dout, err);
    end
    @(posedge clk); #1;
    rstn = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    exp_err = 1'b0;
    @(posedge clk); #1;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    wlog.delete();
    model_pkt(8'h0D, pl, 8'hD0);
    send_pkt(8'h0D, pl, 8'hD0);
    n_checks++;
    if (wlog.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_count: %0d writes, required %0d", wlog.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[i].we !== exp_q[i].we || wlog[i].lfd !== exp_q[i].lfd || wlog[i].d !== exp_q[i].d) begin
        n_fail++;
        $display("FAIL midreset_wr[%0d]: we=%b d=%h, required we=%b d=%h", i,
                 wlog[i].we, wlog[i].d, exp_q[i].we, exp_q[i].d);
      end
    end
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL midreset_err: err=%b, required %b", err, exp_err);
    end
  endtask

  task automatic test_random();
    rnd_env = 1'b1;
    for (int k = 0; k < 31; k++) begin
      bq_t        pl;
      int         n;
      logic [5:0] len;
      logic [1:0] dest;
      logic [7:0] hdr;
      logic [7:0] par;
      dest = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      n = (k == 30) ? 65 : $urandom_range(0, 8);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      if (k == 30) len = 6'd63;
      else len = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(n);
      hdr = {len, dest};
      par = par_of(hdr, pl);
      if ($urandom_range(0, 3) == 0) par = par ^ 8'($urandom_range(1, 255));
      wlog.delete();
      model_pkt(hdr, pl, par);
      send_pkt(hdr, pl, par);
      n_checks++;
      if (wlog.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rnd%0d_count: hdr=%h %0d writes, required %0d", k, hdr, wlog.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
        n_checks++;
        if (wlog[i].we !== exp_q[i].we || wlog[i].lfd !== exp_q[i].lfd || wlog[i].d !== exp_q[i].d) begin
          n_fail++;
          $display("FAIL rnd%0d_wr[%0d]: we=%b lfd=%b d=%h, required we=%b lfd=%b d=%h", k, i,
                   wlog[i].we, wlog[i].lfd, wlog[i].d, exp_q[i].we, exp_q[i].lfd, exp_q[i].d);
        end
      end
      n_checks++;
      if (err !== exp_err) begin
        n_fail++;
        $display("FAIL rnd%0d_err: hdr=%h n=%0d err=%b, required %b", k, hdr, n, err, exp_err);
      end
    end
    rnd_env = 1'b0;
    fifo_full = 3'b000;
    fifo_empty = 3'b111;
  endtask

  initial begin
    rstn = 1'b0;
    pkt_valid = 1'b0;
    data_in = 8'h00;
    fifo_full = 3'b000;
    fifo_empty = 3'b111;
    test_reset();
    test_basic();
    test_bad_parity();
    test_wait_empty();
    test_full_stall();
    test_drop_invalid();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
